// File: rtl/wb_slave_regfile.sv
// wb_slave_regfile: Wishbone B4 classic slave with a bank of NUM_REGS registers.
// Supports byte-lane writes, programmable wait states and per-register
// read-only masking. Out-of-range word indices end with err_o instead of ack_o.
// Register contents are exported in parallel on regs_o.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module wb_slave_regfile #(
  parameter int                     ADDR_WIDTH  = `ADDR_WIDTH,
  parameter int                     DATA_WIDTH  = 32,
  parameter int                     NUM_REGS    = 16,
  parameter int                     WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH-1:0]          adr_i,
  input  logic [DATA_WIDTH-1:0]          dat_i,
  output logic [DATA_WIDTH-1:0]          dat_o,
  input  logic [DATA_WIDTH/8-1:0]        sel_i,
  input  logic                           we_i,
  input  logic                           cyc_i,
  input  logic                           stb_i,
  output logic                           ack_o,
  output logic                           err_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W    = ADDR_WIDTH - OFF_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // FSM state and wait counter
  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;

  // Captured request fields, held constant until the transfer finishes
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [BYTES-1:0]      r_sel;
  logic                  r_we;

  // Registered bus response
  logic                  r_ack;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_dat_o;

  // Control strobes from the next-state logic
  logic                  w_req;
  logic                  w_capture;
  logic                  w_finish;
  logic                  w_in_range;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];

  assign w_req      = cyc_i & stb_i;
  assign w_in_range = ({1'b0, r_idx} < (IDX_W+1)'(NUM_REGS));

  // The byte-offset bits of the address never select anything.
  generate
    if (OFF_BITS > 0) begin : g_off
      logic w_unused_off;
      assign w_unused_off = ^adr_i[OFF_BITS-1:0];
    end
  endgenerate

  // State register and wait counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic. WAIT always lasts WAIT_STATES+1 edges, so the response
  // edge is exactly WAIT_STATES+1 edges after the sampling edge, and the
  // extra RESP->IDLE edge keeps consecutive acks at least three cycles apart.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_capture    = 1'b1;
          w_state_next = S_WAIT;
          w_cnt_next   = 4'(WAIT_STATES);
        end
      end
      S_WAIT: begin
        if (!cyc_i) begin
          // Master abandoned the cycle: drop it silently.
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == 4'd0) begin
          w_state_next = S_RESP;
          w_finish     = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        // Requests still asserted on this edge are deliberately not sampled.
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Capture address, data, lane select and direction when a request is accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx <= '0;
      r_dat <= '0;
      r_sel <= '0;
      r_we  <= 1'b0;
    end else if (w_capture) begin
      r_idx <= adr_i[ADDR_WIDTH-1:OFF_BITS];
      r_dat <= dat_i;
      r_sel <= sel_i;
      r_we  <= we_i;
    end
  end

  // Read multiplexer over the register bank
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_rd_data = w_regs[i];
      end
    end
  end

  // Response generation: ack/err for one cycle, read data loaded on the same edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_ack <= w_finish & w_in_range;
      r_err <= w_finish & ~w_in_range;
      if (w_finish) begin
        if (!w_in_range) begin
          r_dat_o <= '0;
        end else if (!r_we) begin
          r_dat_o <= w_rd_data;
        end
      end
    end
  end

  // Register bank: one flop group per byte lane so each lane has its own enable.
  genvar gi, gb;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic                  w_wr_hit;
      logic [DATA_WIDTH-1:0] w_val;

      // Read-only registers never see a write enable; the bus still gets an ack.
      assign w_wr_hit = w_finish & r_we & (r_idx == IDX_W'(gi)) & ~RO_MASK[gi];

      for (gb = 0; gb < BYTES; gb++) begin : g_lane
        logic [7:0] r_byte;

        // Byte lane update from captured write data when its select bit is set
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            r_byte <= RESET_VALUE[gb*8 +: 8];
          end else if (w_wr_hit && r_sel[gb]) begin
            r_byte <= r_dat[gb*8 +: 8];
          end
        end

        assign w_val[gb*8 +: 8] = r_byte;
      end

      assign w_regs[gi]                          = w_val;
      assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = w_val;
    end
  endgenerate

  assign ack_o = r_ack;
  assign err_o = r_err;
  assign dat_o = r_dat_o;

endmodule

// File: tb/tb_wb_slave_regfile.sv
// tb_wb_slave_regfile: directed literal checks plus randomized transfers,
// all checked every cycle against a transaction-timing model of the slave.
`timescale 1ns/1ps

module tb_wb_slave_regfile;

  localparam int             AW = 8;
  localparam int             DW = 32;
  localparam int             NR = 12;
  localparam int             WS = 3;
  localparam int             FW = NR * DW;
  localparam logic [NR-1:0]  ROM = 12'h002;
  localparam logic [DW-1:0]  RV  = 32'h0000_0000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [AW-1:0]  adr = '0;
  logic [DW-1:0]  dat_in = '0;
  logic [3:0]     sel = '0;
  logic           we = 1'b0;
  logic           cyc = 1'b0;
  logic           stb = 1'b0;
  logic [DW-1:0]  dat_out;
  logic           ack;
  logic           err;
  logic [FW-1:0]  regs;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  wb_slave_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .WAIT_STATES(WS),
    .RO_MASK    (ROM),
    .RESET_VALUE(RV)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .adr_i (adr),
    .dat_i (dat_in),
    .dat_o (dat_out),
    .sel_i (sel),
    .we_i  (we),
    .cyc_i (cyc),
    .stb_i (stb),
    .ack_o (ack),
    .err_o (err),
    .regs_o(regs)
  );

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timing rules: a request seen while free is answered WAIT_STATES+1 edges
  // later unless cyc drops on one of those edges; the edge after a response
  // is never a sampling edge.
  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_dat = '0;
  bit            m_ack = 1'b0;
  bit            m_err = 1'b0;
  bit            chk_en = 1'b0;
  int            edge_n = 0;
  int            free_at = 0;
  int            resp_edge = 0;
  bit            pend = 1'b0;
  int            p_idx = 0;
  logic [DW-1:0] p_dat = '0;
  logic [3:0]    p_sel = '0;
  bit            p_we = 1'b0;
  logic [NR-1:0] ro_v = ROM;

  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        for (int i = 0; i < NR; i++) m_regs[i] = RV;
        m_dat   = '0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        pend    = 1'b0;
        free_at = edge_n + 1;
        chk_en  = 1'b1;
      end else begin
        m_ack = 1'b0;
        m_err = 1'b0;
        if (pend) begin
          if (!cyc) begin
            pend    = 1'b0;
            free_at = edge_n + 1;
          end else if (edge_n == resp_edge) begin
            pend    = 1'b0;
            free_at = edge_n + 2;
            if (p_idx < NR) begin
              m_ack = 1'b1;
              if (p_we) begin
                if (!ro_v[p_idx]) begin
                  for (int b = 0; b < 4; b++)
                    if (p_sel[b]) m_regs[p_idx][b*8 +: 8] = p_dat[b*8 +: 8];
                end
              end else begin
                m_dat = m_regs[p_idx];
              end
            end else begin
              m_err = 1'b1;
              m_dat = '0;
            end
          end
        end else if (edge_n >= free_at && cyc && stb) begin
          pend      = 1'b1;
          resp_edge = edge_n + 1 + WS;
          p_idx     = int'(adr) / (DW / 8);
          p_dat     = dat_in;
          p_sel     = sel;
          p_we      = we;
        end
      end
    end
  end

  // Compare DUT outputs with the model on every falling edge
  initial begin
    logic [FW-1:0] flat;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < NR; i++) flat[i*DW +: DW] = m_regs[i];
        chk("ack_o", FW'(ack), FW'(m_ack));
        chk("err_o", FW'(err), FW'(m_err));
        chk("dat_o", FW'(dat_out), FW'(m_dat));
        chk("regs_o", regs, flat);
      end
    end
  end

  // ---------------- bus driver ----------------
  task automatic xfer(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit w, input int drop_at, input bit hold,
                      output logic [31:0] rd, output bit got_ack, output bit got_err,
                      output int lat);
    int n;
    int bound;
    @(negedge clk);
    adr = a; dat_in = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    got_ack = 1'b0; got_err = 1'b0; rd = '0; lat = 0; n = 0;
    bound = (drop_at != 0) ? drop_at + 8 : 40;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (ack || err) begin
        got_ack = ack; got_err = err; rd = dat_out; lat = n;
        break;
      end
      if (drop_at != 0 && n == drop_at) begin
        cyc = 1'b0; stb = 1'b0;
      end
    end
    if (hold && (got_ack || got_err)) @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    if (drop_at == 0) chk("xfer_done", FW'(got_ack | got_err), FW'(1));
  endtask

  initial begin
    logic [31:0] rd;
    bit ga, ge;
    int lat;
    logic [7:0] a;
    int idx;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset value and latency
    xfer(8'h00, 32'h0, 4'hF, 1'b0, 0, 1'b0, rd, ga, ge, lat);
    chk("rd0_lat", FW'(lat), FW'(5));
    chk("rd0_ack", FW'(ga), FW'(1));
    chk("rd0_err", FW'(ge), FW'(0));
    chk("rd0_dat", FW'(rd), FW'(32'h0000_0000));

    // Full-word write and readback
    xfer(8'h14, 32'hDEADBEEF, 4'hF, 1'b1, 0, 1'b0, rd, ga, ge, lat);
    chk("wr5_ack", FW'(ga), FW'(1));
    xfer(8'h14, 32'h0, 4'hF, 1'b0, 0, 1'b0, rd, ga, ge, lat);
    chk("rd5_dat", FW'(rd), FW'(32'hDEADBEEF));
    chk("regs_o_r5", FW'(regs[191:160]), FW'(32'hDEADBEEF));

    // Byte lanes; low address bits ignored on the readback
    xfer(8'h08, 32'h11223344, 4'b0101, 1'b1, 0, 1'b0, rd, ga, ge, lat);
    xfer(8'h0B, 32'h0, 4'h0, 1'b0, 0, 1'b0, rd, ga, ge, lat);
    chk("rd2_lanes", FW'(rd), FW'(32'h00220044));
    xfer(8'h08, 32'hFFFFFFFF, 4'h0, 1'b1, 0, 1'b0, rd, ga, ge, lat);
    chk("wr2_sel0_ack", FW'(ga), FW'(1));
    xfer(8'h08, 32'h0, 4'hF, 1'b0, 0, 1'b0, rd, ga, ge, lat);
    chk("rd2_sel0", FW'(rd), FW'(32'h00220044));

    // Read-only register
    xfer(8'h04, 32'hFFFFFFFF, 4'hF, 1'b1, 0, 1'b0, rd, ga, ge, lat);
    chk("wr_ro_ack", FW'(ga), FW'(1));
    xfer(8'h04, 32'h0, 4'hF, 1'b0, 0, 1'b0, rd, ga, ge, lat);
    chk("rd_ro_dat", FW'(rd), FW'(32'h0000_0000));

    // Range boundaries
    xfer(8'h40, 32'h0, 4'hF, 1'b0, 0, 1'b0, rd, ga, ge, lat);
    chk("oor_err", FW'(ge), FW'(1));
    chk("oor_ack", FW'(ga), FW'(0));
    chk("oor_dat", FW'(rd), FW'(32'h0));
    chk("oor_lat", FW'(lat), FW'(5));
    xfer(8'h2C, 32'h0, 4'hF, 1'b0, 0, 1'b0, rd, ga, ge, lat);
    chk("last_ack", FW'(ga), FW'(1));
    xfer(8'h30, 32'h0, 4'hF, 1'b0, 0, 1'b0, rd, ga, ge, lat);
    chk("first_oor_err", FW'(ge), FW'(1));

    // Aborted transfers
    xfer(8'h00, 32'h0, 4'hF, 1'b0, 2, 1'b0, rd, ga, ge, lat);
    chk("abort_rd_resp", FW'(ga | ge), FW'(0));
    xfer(8'h14, 32'h12345678, 4'hF, 1'b1, 2, 1'b0, rd, ga, ge, lat);
    chk("abort_wr_resp", FW'(ga | ge), FW'(0));
    xfer(8'h14, 32'h0, 4'hF, 1'b0, 0, 1'b0, rd, ga, ge, lat);
    chk("after_abort_dat", FW'(rd), FW'(32'hDEADBEEF));

    // Reset during WAIT of a write
    @(negedge clk);
    adr = 8'h0C; dat_in = 32'hA5A5A5A5; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_ack_a", FW'(ack), FW'(0));
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_ack_b", FW'(ack), FW'(0));
    xfer(8'h0C, 32'h0, 4'hF, 1'b0, 0, 1'b0, rd, ga, ge, lat);
    chk("rstw_dat", FW'(rd), FW'(RV));
    xfer(8'h14, 32'h0, 4'hF, 1'b0, 0, 1'b0, rd, ga, ge, lat);
    chk("rst_clears_r5", FW'(rd), FW'(RV));

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) != 0) idx = $urandom_range(0, NR - 1);
      else idx = $urandom_range(NR, 63);
      a = 8'(idx * 4 + $urandom_range(0, 3));
      case ($urandom_range(0, 19))
        0: begin
          @(negedge clk); rst = 1'b1;
          @(negedge clk); rst = 1'b0;
        end
        1: begin
          @(negedge clk);
          adr = a; we = 1'b1; dat_in = $urandom; sel = 4'hF;
          if ($urandom_range(0, 1) != 0) begin cyc = 1'b1; stb = 1'b0; end
          else begin cyc = 1'b0; stb = 1'b1; end
          @(negedge clk); cyc = 1'b0; stb = 1'b0;
        end
        2, 3:
          xfer(a, $urandom, 4'($urandom), 1'($urandom), $urandom_range(1, WS + 1),
               1'b0, rd, ga, ge, lat);
        default:
          xfer(a, $urandom, 4'($urandom), 1'($urandom), 0, 1'($urandom),
               rd, ga, ge, lat);
      endcase
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
